// File: rtl/pdes_pkg.sv
// Shared constants and types for the event-gathering path:
// core count, event word width, and a width helper.
package pdes_pkg;

  localparam int NR = 4;
  localparam int DW = 64;

  typedef logic [DW-1:0] evt_word_t;

  // Ceiling log2, never less than 1, so that index fields always have at least one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// First-word-fall-through FIFO. Storage is uninitialised; the pointers and the
// occupancy count are cleared by reset.
module evt_fifo
  import pdes_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 66,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/evt_gather.sv
// Captures the granted core's event word into a FIFO, back-pressures the arbiter
// when full, acks the captured core, and tracks the occupancy high-water mark.
module evt_gather
  import pdes_pkg::*;
#(
  parameter int NR    = pdes_pkg::NR,
  parameter int DW    = pdes_pkg::DW,
  parameter int DEPTH = 8,
  localparam int SW   = clog2(NR),
  localparam int AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NR*DW-1:0] evt_data,
  input  logic             eval,
  input  logic [SW-1:0]    egnt,
  output logic             stall,
  output logic [NR-1:0]    ack,
  output logic             out_vld,
  output logic [DW-1:0]    out_data,
  output logic [SW-1:0]    out_src,
  input  logic             out_rdy,
  output logic [AW:0]      hwm
);

  localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [DW-1:0]    words [NR];
  logic [DW-1:0]    sel_word;
  logic             grant_ok;
  logic             push;
  logic             pop;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic [SW+DW-1:0] fifo_dout;
  logic [NR-1:0]    ack_reg;
  logic [AW:0]      hwm_reg;

  for (genvar gi = 0; gi < NR; gi++) begin : g_words
    assign words[gi] = evt_data[gi*DW +: DW];
  end

  // Out-of-range grants (non-power-of-two NR) select nothing and are dropped.
  always_comb begin
    sel_word = '0;
    grant_ok = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if (egnt == SW'(i)) begin
        sel_word = words[i];
        grant_ok = 1'b1;
      end
    end
  end

  assign stall   = (count == CNT_FULL);
  assign out_vld = (count != '0);
  assign push    = eval & ~stall & grant_ok;
  assign pop     = out_vld & out_rdy;

  evt_fifo #(
    .DEPTH (DEPTH),
    .W     (SW + DW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({egnt, sel_word}),
    .dout  (fifo_dout),
    .count (count)
  );

  assign out_src  = fifo_dout[SW+DW-1:DW];
  assign out_data = fifo_dout[DW-1:0];

  always_comb begin
    case ({push, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  for (genvar gi = 0; gi < NR; gi++) begin : g_ack
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) ack_reg[gi] <= 1'b0;
      else        ack_reg[gi] <= push && (egnt == SW'(gi));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 hwm_reg <= '0;
    else if (count_next > hwm_reg) hwm_reg <= count_next;
  end

  assign ack = ack_reg;
  assign hwm = hwm_reg;

endmodule

// File: doc/evt_gather.md
EVT_GATHER -- requirements
Module: evt_gather

Interface
REQ-001 Parameter NR, default 4: number of requesting cores; matches the arbiter NR.
REQ-002 Parameter DW, default 64: event word width.
REQ-003 Parameter DEPTH, default 8: FIFO entries; must be a power of two, at least 2.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 evt_data  input  NR*DW  concatenated core event words; core i occupies bits [i*DW +: DW].
REQ-007 eval  input  1  arbiter grant valid.
REQ-008 egnt  input  log2(NR)  arbiter encoded grant index.
REQ-009 stall  output  1  back-pressure to the arbiter; grant must be held while high.
REQ-010 ack  output  NR  one-hot, one-cycle pulse to the core whose event was captured.
REQ-011 out_vld  output  1  head-of-FIFO event valid.
REQ-012 out_data  output  DW  head event word.
REQ-013 out_src  output  log2(NR)  source core index of the head event.
REQ-014 out_rdy  input  1  downstream accepts the head event when out_vld and out_rdy are both high.
REQ-015 hwm  output  log2(DEPTH)+1  occupancy high-water mark since reset.

Function
REQ-016 Push condition: eval=1 and stall=0. On the same rising edge, {egnt, evt_data[egnt*DW +: DW]} is written at wr_ptr.
REQ-017 stall shall be combinational: 1 exactly when count==DEPTH, independent of out_rdy in the same cycle.
REQ-018 Pop condition: out_vld=1 and out_rdy=1; rd_ptr advances on that edge.
REQ-019 FIFO is first-word-fall-through: out_vld=(count!=0); out_data and out_src come directly from the rd_ptr entry.
REQ-020 Push to an empty FIFO: out_vld rises the cycle after the push edge; latency is 1 cycle.
REQ-021 Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-022 count is log2(DEPTH)+1 bits, range 0..DEPTH. Per edge: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-023 Simultaneous push and pop with count==0 is impossible, because out_vld=0. The push proceeds and count becomes 1.
REQ-024 Push and pop in the same cycle with 0<count<DEPTH: both take effect and count is unchanged.
REQ-025 count==DEPTH with pop: the push is blocked by stall (REQ-017), so count becomes DEPTH-1 and stall falls the next cycle.
REQ-026 ack is registered: ack[egnt] is 1 for exactly the cycle after each accepted push; all other bits are 0.
REQ-027 eval=1 while stall=1 produces no write and no ack.
REQ-028 hwm updates to the new count whenever the new count exceeds hwm; it never decreases except on reset.
REQ-029 egnt >= NR while eval=1 (possible only for non-power-of-two NR): the event is dropped, no ack is issued, and stall is unaffected.

Reset
REQ-030 Asserting reset forces wr_ptr=0, rd_ptr=0, count=0, hwm=0 and ack=0 immediately.
REQ-031 During reset, out_vld=0 and stall=0; FIFO storage contents are not reset and are don't-care.
REQ-032 Reset asserted mid-operation discards all queued events; no ack pulse is emitted after reset asserts.
REQ-033 Reset deassertion is synchronised externally; the first push may occur on the first rising edge after deassertion.

Structure
REQ-034 Shared package pdes_pkg holds NR, DW, the event word typedef, and a clog2 constant function used for egnt, out_src and pointer widths.
REQ-035 Storage, pointers and count live in one sub-module, evt_fifo (parameters DEPTH and width DW+log2(NR); ports push, pop, din, dout, count).
REQ-036 The top level contains the grant mux, stall, ack and hwm logic only.

Verification
REQ-037 Single event: core 2 data 0xA5, eval=1, egnt=2, out_rdy=1.
-> ack=4'b0100 next cycle; out_vld=1 with out_data=0xA5, out_src=2 next cycle.
REQ-038 Fill: out_rdy=0 and 9 consecutive grants from cores 0,1,2,3,0,...
-> stall=1 after the 8th push; the 9th grant gets no ack; hwm=8.
-> with out_rdy=1, out_src reads 0,1,2,3,0,1,2,3, then the 9th event.
REQ-039 Full plus pop: count=8, eval=1, out_rdy=1.
-> no push that cycle; count=7 and stall=0 next cycle; the push happens the cycle after.
REQ-040 Steady stream: eval=1 and out_rdy=1 every cycle for 20 cycles after one prefill.
-> count stays 1; pointers wrap twice; data order is preserved.
REQ-041 Reset mid-run: count=5, then reset pulsed low for 1 ns between edges.
-> out_vld=0, stall=0, hwm=0 and ack=0 immediately; no stale event appears afterwards.
REQ-042 Arbiter co-simulation: rrarb with NR=4, PIPE=0 and all four cores requesting, DEPTH=8, out_rdy toggling 1010...
-> every event is delivered exactly once, in grant order, with matching out_src.
